// File: rtl/apb_cmd_master.sv
// apb_cmd_master: turns a valid/ready command stream into single APB
// transfers and reports read data, slave error and timeout on a
// valid/ready response channel. One transfer is in flight at a time.
module apb_cmd_master #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic              clk_in,
  input  logic              reset_int,
  // command channel
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic              cmd_write,
  // response channel
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              busy,
  // APB requester
  output logic [ADDR_W-1:0] PADDR,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  // A zero TIMEOUT_CYCLES disables the abort path entirely; the compare
  // value is forced to zero then so the cast never sees a negative number.
  localparam bit               TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT_CYCLES == 0) ? '0
                                         : CNT_W'(TIMEOUT_CYCLES - 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  wait_cnt, wait_cnt_nxt;
  logic [ADDR_W-1:0] paddr_nxt;
  logic [DATA_W-1:0] pwdata_nxt;
  logic              pwrite_nxt;
  logic              psel_nxt;
  logic              penable_nxt;
  logic              rsp_valid_nxt;
  logic [DATA_W-1:0] rsp_rdata_nxt;
  logic              rsp_err_nxt;
  logic              rsp_timeout_nxt;

  // The command side only ever sees the state register, so acceptance is
  // never combinationally dependent on the response side (no bypass).
  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // State register plus every registered output; reset drops any transfer
  // and any pending response on the spot.
  always_ff @(posedge clk_in or posedge reset_int) begin
    if (reset_int) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      PADDR       <= '0;
      PWDATA      <= '0;
      PWRITE      <= 1'b0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      wait_cnt    <= wait_cnt_nxt;
      PADDR       <= paddr_nxt;
      PWDATA      <= pwdata_nxt;
      PWRITE      <= pwrite_nxt;
      PSEL        <= psel_nxt;
      PENABLE     <= penable_nxt;
      rsp_valid   <= rsp_valid_nxt;
      rsp_rdata   <= rsp_rdata_nxt;
      rsp_err     <= rsp_err_nxt;
      rsp_timeout <= rsp_timeout_nxt;
    end
  end

  // Next-state and next-output decode; everything holds unless a state
  // below changes it, which keeps PADDR/PWDATA/PWRITE at their last values.
  always_comb begin
    state_nxt       = state;
    wait_cnt_nxt    = wait_cnt;
    paddr_nxt       = PADDR;
    pwdata_nxt      = PWDATA;
    pwrite_nxt      = PWRITE;
    psel_nxt        = PSEL;
    penable_nxt     = PENABLE;
    rsp_valid_nxt   = rsp_valid;
    rsp_rdata_nxt   = rsp_rdata;
    rsp_err_nxt     = rsp_err;
    rsp_timeout_nxt = rsp_timeout;

    case (state)
      IDLE: begin
        if (cmd_valid) begin
          paddr_nxt  = cmd_addr;
          pwdata_nxt = cmd_wdata;
          pwrite_nxt = cmd_write;
          psel_nxt   = 1'b1;
          state_nxt  = SETUP;
        end
      end

      SETUP: begin
        penable_nxt  = 1'b1;
        wait_cnt_nxt = '0;
        state_nxt    = ACCESS;
      end

      ACCESS: begin
        // PREADY is checked first so a ready slave beats a same-cycle timeout.
        if (PREADY) begin
          psel_nxt        = 1'b0;
          penable_nxt     = 1'b0;
          rsp_rdata_nxt   = PWRITE ? '0 : PRDATA;
          rsp_err_nxt     = PSLVERR;
          rsp_timeout_nxt = 1'b0;
          rsp_valid_nxt   = 1'b1;
          state_nxt       = RESP;
        end else if (TO_EN && (wait_cnt == TO_LAST)) begin
          psel_nxt        = 1'b0;
          penable_nxt     = 1'b0;
          rsp_rdata_nxt   = '0;
          rsp_err_nxt     = 1'b1;
          rsp_timeout_nxt = 1'b1;
          rsp_valid_nxt   = 1'b1;
          state_nxt       = RESP;
        end else begin
          wait_cnt_nxt = wait_cnt + 1'b1;
        end
      end

      RESP: begin
        if (rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          state_nxt     = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
